// File: rtl/simon_playback_sequencer_pkg.sv
// Shared state encodings and default sizing for the Simon playback sequencer.
// States stay plain 3-bit constants so SimonControl can reuse the same codes.
package simon_playback_sequencer_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_READ = 3'd1;
  localparam logic [2:0] ST_LOAD = 3'd2;
  localparam logic [2:0] ST_SHOW = 3'd3;
  localparam logic [2:0] ST_GAP  = 3'd4;
  localparam logic [2:0] ST_DONE = 3'd5;

  localparam int DEF_ADDR_W   = 6;
  localparam int DEF_LED_W    = 4;
  localparam int DEF_HOLD_CYC = 8;
  localparam int DEF_GAP_CYC  = 2;
  localparam int TMR_W        = 8;

  function automatic logic st_busy(input logic [2:0] st);
    return (st == ST_READ) || (st == ST_LOAD) || (st == ST_SHOW) || (st == ST_GAP);
  endfunction

endpackage

// File: rtl/simon_playback_sequencer_timer.sv
// Loadable down-counter shared by the SHOW and GAP phases.
// Load N-1 to get N cycles in the phase; expired is high while the count sits at zero.
module simon_playback_sequencer_timer
  import simon_playback_sequencer_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [TMR_W-1:0] i_value,
  output logic             o_expired
);

  logic [TMR_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_value;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/simon_playback_sequencer.sv
// Playback engine: walks pattern memory 0..n-1, showing each entry for HOLD_CYC cycles
// followed by GAP_CYC blank cycles, then pulses done. Abort returns to IDLE silently.
module simon_playback_sequencer
  import simon_playback_sequencer_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int LED_W    = DEF_LED_W,
  parameter int HOLD_CYC = DEF_HOLD_CYC,
  parameter int GAP_CYC  = DEF_GAP_CYC
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [ADDR_W:0]   i_num_stored,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [LED_W-1:0]  i_rd_data,
  output logic [LED_W-1:0]  o_pattern_leds,
  output logic [ADDR_W-1:0] o_step_idx,
  output logic              o_busy,
  output logic              o_done
);

  localparam logic [TMR_W-1:0] HOLD_LD = TMR_W'(HOLD_CYC - 1);
  localparam logic [TMR_W-1:0] GAP_LD  = TMR_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [ADDR_W:0]  ONE     = (ADDR_W+1)'(1);

  logic [2:0]        r_state;
  logic [ADDR_W:0]   r_idx;
  logic [ADDR_W:0]   r_n;
  logic [LED_W-1:0]  r_leds;

  logic [2:0]        w_next_state;
  logic              w_step_end;
  logic              w_last;
  logic              w_tmr_load;
  logic [TMR_W-1:0]  w_tmr_value;
  logic              w_tmr_expired;

  simon_playback_sequencer_timer u_timer (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_load    (w_tmr_load),
    .i_value   (w_tmr_value),
    .o_expired (w_tmr_expired)
  );

  // Index and count are ADDR_W+1 bits so a full 2**ADDR_W playlist never wraps.
  assign w_last = (r_idx == (r_n - ONE));

  always_comb begin
    w_next_state = r_state;
    w_step_end   = 1'b0;
    case (r_state)
      ST_IDLE: if (i_start) w_next_state = (i_num_stored == '0) ? ST_DONE : ST_READ;
      ST_READ: w_next_state = ST_LOAD;
      ST_LOAD: w_next_state = ST_SHOW;
      ST_SHOW: begin
        if (w_tmr_expired) begin
          if (GAP_CYC == 0) w_step_end = 1'b1;
          else              w_next_state = ST_GAP;
        end
      end
      ST_GAP:  if (w_tmr_expired) w_step_end = 1'b1;
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
    if (w_step_end) w_next_state = w_last ? ST_DONE : ST_READ;
    if (i_abort)    w_next_state = ST_IDLE;
  end

  always_comb begin
    w_tmr_load  = (r_state == ST_LOAD) ||
                  ((r_state == ST_SHOW) && w_tmr_expired && (GAP_CYC != 0));
    w_tmr_value = (r_state == ST_LOAD) ? HOLD_LD : GAP_LD;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_n     <= '0;
      r_leds  <= '0;
    end else begin
      r_state <= w_next_state;
      if ((r_state == ST_IDLE) && i_start && !i_abort) begin
        r_n   <= i_num_stored;
        r_idx <= '0;
      end else if (w_step_end && !w_last && !i_abort) begin
        r_idx <= r_idx + ONE;
      end
      // LEDs only carry data from the LOAD capture until SHOW runs out.
      if (!i_abort && (r_state == ST_LOAD)) begin
        r_leds <= i_rd_data;
      end else if (!(!i_abort && (r_state == ST_SHOW) && !w_tmr_expired)) begin
        r_leds <= '0;
      end
    end
  end

  assign o_rd_en        = (r_state == ST_READ);
  assign o_rd_addr      = r_idx[ADDR_W-1:0];
  assign o_step_idx     = r_idx[ADDR_W-1:0];
  assign o_pattern_leds = r_leds;
  assign o_busy         = st_busy(r_state);
  assign o_done         = (r_state == ST_DONE);

endmodule

// File: tb/tb_simon_playback_sequencer.sv
// Directed bench: a default build (HOLD 8, GAP 2) and a GAP_CYC=0 build share stimulus;
// each has its own registered memory model returning junk when not read.
module tb_simon_playback_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort_s = 1'b0;
  logic [6:0] num_stored = '0;

  logic       rd_en_a, busy_a, done_a, rd_en_b, busy_b, done_b;
  logic [5:0] rd_addr_a, step_a, rd_addr_b, step_b;
  logic [3:0] rd_data_a, leds_a, rd_data_b, leds_b;
  logic [3:0] mem [64];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  simon_playback_sequencer dut_a (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort_s), .i_num_stored(num_stored),
    .o_rd_en(rd_en_a), .o_rd_addr(rd_addr_a), .i_rd_data(rd_data_a),
    .o_pattern_leds(leds_a), .o_step_idx(step_a), .o_busy(busy_a), .o_done(done_a)
  );

  simon_playback_sequencer #(.GAP_CYC(0)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort_s), .i_num_stored(num_stored),
    .o_rd_en(rd_en_b), .o_rd_addr(rd_addr_b), .i_rd_data(rd_data_b),
    .o_pattern_leds(leds_b), .o_step_idx(step_b), .o_busy(busy_b), .o_done(done_b)
  );

  always @(posedge clk) begin
    rd_data_a <= rd_en_a ? mem[rd_addr_a] : 4'($urandom);
    rd_data_b <= rd_en_b ? mem[rd_addr_b] : 4'($urandom);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // k counts edges after the one following which start was driven; start is seen at k=1.
  function automatic logic [3:0] exp_leds(int k, int n, int hold, int gap);
    int j, step, off;
    if (k < 3) return 4'd0;
    j = k - 3;
    step = j / (2 + hold + gap);
    off = j % (2 + hold + gap);
    if (step < n && off < hold) return mem[step];
    return 4'd0;
  endfunction

  function automatic logic exp_rd(int k, int n, int period);
    return (k >= 1) && ((k - 1) % period == 0) && ((k - 1) / period < n);
  endfunction

  task automatic pulse_start(input int n);
    num_stored = 7'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks += 2;
    if ({leds_a, rd_en_a, rd_addr_a, step_a, busy_a, done_a} !== 19'd0)
      begin failures++; $display("FAIL reset_a outputs=%h want 0", {leds_a, rd_en_a, rd_addr_a, step_a, busy_a, done_a}); end
    if ({leds_b, rd_en_b, rd_addr_b, step_b, busy_b, done_b} !== 19'd0)
      begin failures++; $display("FAIL reset_b outputs=%h want 0", {leds_b, rd_en_b, rd_addr_b, step_b, busy_b, done_b}); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_play(input bit restart_spam);
    pulse_start(3);
    num_stored = 7'd1;
    for (int k = 1; k <= 40; k++) begin
      checks += 4;
      if (leds_a !== exp_leds(k, 3, 8, 2))
        begin failures++; $display("FAIL play_leds k=%0d spam=%0d got=%0d want=%0d", k, restart_spam, leds_a, exp_leds(k, 3, 8, 2)); end
      if (done_a !== 1'(k == 37))
        begin failures++; $display("FAIL play_done k=%0d spam=%0d got=%0b", k, restart_spam, done_a); end
      if (busy_a !== 1'(k <= 36))
        begin failures++; $display("FAIL play_busy k=%0d spam=%0d got=%0b", k, restart_spam, busy_a); end
      if (rd_en_a !== exp_rd(k, 3, 12))
        begin failures++; $display("FAIL play_rden k=%0d spam=%0d got=%0b", k, restart_spam, rd_en_a); end
      if (rd_en_a) begin
        checks++;
        if (rd_addr_a !== 6'((k - 1) / 12))
          begin failures++; $display("FAIL play_addr k=%0d got=%0d want=%0d", k, rd_addr_a, (k - 1) / 12); end
      end
      start = restart_spam && (k < 36);
      tick();
    end
    start = 1'b0;
  endtask

  task automatic test_zero_entries();
    pulse_start(0);
    checks += 3;
    if (done_a !== 1'b1) begin failures++; $display("FAIL zero_done got=%0b want=1", done_a); end
    if (busy_a !== 1'b0) begin failures++; $display("FAIL zero_busy got=%0b want=0", busy_a); end
    if (rd_en_a !== 1'b0) begin failures++; $display("FAIL zero_rden got=%0b want=0", rd_en_a); end
    for (int k = 2; k <= 5; k++) begin
      tick();
      checks++;
      if ({rd_en_a, busy_a, done_a} !== 3'b000)
        begin failures++; $display("FAIL zero_idle k=%0d rd_en/busy/done=%b want 000", k, {rd_en_a, busy_a, done_a}); end
    end
  endtask

  task automatic test_abort();
    pulse_start(3);
    for (int k = 1; k < 17; k++) tick();
    checks++;
    if (leds_a !== mem[1]) begin failures++; $display("FAIL abort_pre_leds got=%0d want=%0d", leds_a, mem[1]); end
    abort_s = 1'b1;
    tick();
    abort_s = 1'b0;
    checks++;
    if ({leds_a, rd_en_a, busy_a, done_a} !== 7'd0)
      begin failures++; $display("FAIL abort_next got=%b want 0", {leds_a, rd_en_a, busy_a, done_a}); end
    for (int k = 0; k < 30; k++) begin
      tick();
      checks++;
      if ({busy_a, done_a} !== 2'b00) begin failures++; $display("FAIL abort_quiet k=%0d busy/done=%b", k, {busy_a, done_a}); end
    end
    num_stored = 7'd3;
    start = 1'b1;
    abort_s = 1'b1;
    tick();
    start = 1'b0;
    abort_s = 1'b0;
    checks++;
    if (busy_a !== 1'b0) begin failures++; $display("FAIL abort_beats_start busy=%0b want 0", busy_a); end
    pulse_start(3);
    checks += 2;
    if (!(rd_en_a === 1'b1 && rd_addr_a === 6'd0))
      begin failures++; $display("FAIL replay_first_read rd_en=%0b addr=%0d want 1/0", rd_en_a, rd_addr_a); end
    tick();
    tick();
    if (leds_a !== mem[0]) begin failures++; $display("FAIL replay_leds got=%0d want=%0d", leds_a, mem[0]); end
    for (int k = 3; k < 40; k++) tick();
  endtask

  task automatic test_reset_in_gap();
    pulse_start(3);
    for (int k = 1; k < 23; k++) tick();
    checks++;
    if ({busy_a, leds_a, step_a} !== {1'b1, 4'd0, 6'd1})
      begin failures++; $display("FAIL gap_pre busy=%0b leds=%0d step=%0d want 1/0/1", busy_a, leds_a, step_a); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({leds_a, rd_en_a, rd_addr_a, step_a, busy_a, done_a} !== 19'd0)
      begin failures++; $display("FAIL gap_reset outputs=%h want 0", {leds_a, rd_en_a, rd_addr_a, step_a, busy_a, done_a}); end
    tick();
  endtask

  task automatic test_no_gap_build();
    pulse_start(3);
    for (int k = 1; k <= 40; k++) begin
      checks += 4;
      if (leds_b !== exp_leds(k, 3, 8, 0))
        begin failures++; $display("FAIL nogap_leds k=%0d got=%0d want=%0d", k, leds_b, exp_leds(k, 3, 8, 0)); end
      if (done_b !== 1'(k == 31))
        begin failures++; $display("FAIL nogap_done k=%0d got=%0b", k, done_b); end
      if (busy_b !== 1'(k <= 30))
        begin failures++; $display("FAIL nogap_busy k=%0d got=%0b", k, busy_b); end
      if (rd_en_b !== exp_rd(k, 3, 10))
        begin failures++; $display("FAIL nogap_rden k=%0d got=%0b", k, rd_en_b); end
      tick();
    end
  endtask

  task automatic test_full_memory();
    int reads = 0;
    pulse_start(64);
    for (int k = 1; k <= 780; k++) begin
      checks += 2;
      if (leds_a !== exp_leds(k, 64, 8, 2))
        begin failures++; $display("FAIL full_leds k=%0d got=%0d want=%0d", k, leds_a, exp_leds(k, 64, 8, 2)); end
      if (done_a !== 1'(k == 769))
        begin failures++; $display("FAIL full_done k=%0d got=%0b", k, done_a); end
      if (rd_en_a) begin
        checks++;
        if (rd_addr_a !== 6'(reads))
          begin failures++; $display("FAIL full_addr k=%0d got=%0d want=%0d", k, rd_addr_a, reads); end
        reads++;
      end
      tick();
    end
    checks++;
    if (reads != 64) begin failures++; $display("FAIL full_read_count got=%0d want=64", reads); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 4'(((i * 7) % 15) + 1);
    mem[0] = 4'd1;
    mem[1] = 4'd2;
    mem[2] = 4'd4;
    test_reset();
    test_single_play(1'b0);
    test_zero_entries();
    test_abort();
    test_single_play(1'b1);
    test_reset_in_gap();
    test_no_gap_build();
    test_full_memory();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
